// File: rtl/wifi_dma_pkg.sv
// wifi_dma_pkg: shared FSM states, channel ids and fixed AHB encodings for the WiFi DMA master
package wifi_dma_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_ACK} state_e;
  typedef enum logic {CH_TX, CH_RX} ch_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
endpackage

// File: rtl/wifi_ahb_dma_master_if.sv
// wifi_ahb_dma_master_if: AHB-Lite master/slave signal bundle
interface wifi_ahb_dma_master_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] HADDR;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic HWRITE;
  logic HREADY;
  logic HRESP;
  modport master(output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, input HRDATA, HREADY, HRESP);
  modport slave(input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/wifi_dma_channel.sv
// wifi_dma_channel: per-channel memory pointer, remaining-word counter and arm flag
module wifi_dma_channel
  import wifi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic word_done,
  input  logic disarm,
  output logic armed,
  output logic [DATA_WIDTH-1:0] addr,
  output logic [LEN_WIDTH-1:0] remaining
);
  logic armed_q, armed_d, load;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  // a start while armed is dropped so an in-flight transfer keeps its pointer
  always_comb begin
    load = start && !armed_q && cfg_len != '0;
    armed_d = load || (armed_q && !disarm);
    addr_d = load ? (cfg_addr & ~DATA_WIDTH'(3)) : word_done ? addr_q + DATA_WIDTH'(4) : addr_q;
    rem_d = load ? cfg_len : word_done ? rem_q - LEN_WIDTH'(1) : rem_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      armed_q <= 1'b0;
      addr_q <= '0;
      rem_q <= '0;
    end else begin
      armed_q <= armed_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
    end
  assign armed = armed_q;
  assign addr = addr_q;
  assign remaining = rem_q;
endmodule

// File: rtl/wifi_ahb_dma_master.sv
// wifi_ahb_dma_master: AHB-Lite initiator moving word blocks between memory and the WiFi PHY FIFOs
module wifi_ahb_dma_master
  import wifi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  parameter int BLOCK_LEN = 4,
  parameter logic [DATA_WIDTH-1:0] TX_FIFO_ADDR = 32'h4000_0010,
  parameter logic [DATA_WIDTH-1:0] RX_FIFO_ADDR = 32'h4000_0014
) (
  input  logic HCLK,
  input  logic reset,
  wifi_ahb_dma_master_if.master ahb,
  input  logic DMA_WRITE_REQ,
  input  logic DMA_READ_REQ,
  output logic DMA_WRITE_ACK,
  output logic DMA_READ_ACK,
  output logic DMA_WRITE_DONE,
  output logic DMA_READ_DONE,
  input  logic tx_start,
  input  logic rx_start,
  input  logic [DATA_WIDTH-1:0] cfg_tx_addr,
  input  logic [DATA_WIDTH-1:0] cfg_rx_addr,
  input  logic [LEN_WIDTH-1:0] cfg_tx_len,
  input  logic [LEN_WIDTH-1:0] cfg_rx_len,
  output logic busy,
  output logic err_irq
);
  localparam int BW = $clog2(BLOCK_LEN + 1);
  state_e state_q, state_d;
  ch_e cur_q, cur_d, last_q, last_d, arb_ch;
  logic [1:0] pend_q, pend_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, tx_addr, rx_addr;
  logic [LEN_WIDTH-1:0] tx_rem, rx_rem, arb_rem, cur_rem;
  logic err_q, err_d, tx_armed, rx_armed, word_done, abort, blk_end;
  // round-robin: with both pending, the channel served last time yields
  assign arb_ch = (pend_q == 2'b11) ? ((last_q == CH_TX) ? CH_RX : CH_TX) : (pend_q[1] ? CH_RX : CH_TX);
  assign arb_rem = (arb_ch == CH_TX) ? tx_rem : rx_rem;
  assign cur_rem = (cur_q == CH_TX) ? tx_rem : rx_rem;
  assign word_done = state_q == S_WR_D && ahb.HREADY && !ahb.HRESP;
  assign abort = (state_q == S_RD_D || state_q == S_WR_D) && ahb.HREADY && ahb.HRESP;
  assign blk_end = state_q == S_ACK && cur_rem == '0;
  wifi_dma_channel #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_tx (
    .clk(HCLK), .rst(reset), .start(tx_start), .cfg_addr(cfg_tx_addr), .cfg_len(cfg_tx_len),
    .word_done(word_done && cur_q == CH_TX), .disarm((abort || blk_end) && cur_q == CH_TX),
    .armed(tx_armed), .addr(tx_addr), .remaining(tx_rem)
  );
  wifi_dma_channel #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_rx (
    .clk(HCLK), .rst(reset), .start(rx_start), .cfg_addr(cfg_rx_addr), .cfg_len(cfg_rx_len),
    .word_done(word_done && cur_q == CH_RX), .disarm((abort || blk_end) && cur_q == CH_RX),
    .armed(rx_armed), .addr(rx_addr), .remaining(rx_rem)
  );
  always_ff @(posedge HCLK or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cur_q <= CH_TX;
      last_q <= CH_RX;
      pend_q <= '0;
      blk_q <= '0;
      hold_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      last_q <= last_d;
      pend_q <= pend_d;
      blk_q <= blk_d;
      hold_q <= hold_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    last_d = last_q;
    pend_d = pend_q;
    blk_d = blk_q;
    hold_d = hold_q;
    err_d = abort ? 1'b1 : (tx_start || rx_start) ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        pend_d = {rx_armed && DMA_READ_REQ, tx_armed && DMA_WRITE_REQ};
        state_d = (|pend_d) ? S_ARB : S_IDLE;
      end
      S_ARB: begin
        cur_d = arb_ch;
        last_d = arb_ch;
        blk_d = (arb_rem < LEN_WIDTH'(BLOCK_LEN)) ? BW'(arb_rem) : BW'(BLOCK_LEN);
        state_d = S_RD_A;
      end
      S_RD_A: state_d = ahb.HREADY ? S_RD_D : S_RD_A;
      S_RD_D: begin
        if (abort) state_d = S_IDLE;
        else if (ahb.HREADY) begin
          hold_d = ahb.HRDATA;
          state_d = S_WR_A;
        end
      end
      S_WR_A: state_d = ahb.HREADY ? S_WR_D : S_WR_A;
      S_WR_D: begin
        if (abort) state_d = S_IDLE;
        else if (word_done) begin
          blk_d = blk_q - BW'(1);
          state_d = (blk_q == BW'(1)) ? S_ACK : S_RD_A;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    ahb.HTRANS = (state_q == S_RD_A || state_q == S_WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    ahb.HWRITE = state_q == S_WR_A;
    ahb.HADDR = (state_q == S_RD_A) ? ((cur_q == CH_TX) ? tx_addr : RX_FIFO_ADDR) :
                (state_q == S_WR_A) ? ((cur_q == CH_TX) ? TX_FIFO_ADDR : rx_addr) : '0;
    ahb.HWDATA = (state_q == S_WR_D) ? hold_q : '0;
    ahb.HSIZE = HSIZE_WORD;
    ahb.HBURST = HBURST_SINGLE;
    DMA_WRITE_ACK = state_q == S_ACK && cur_q == CH_TX;
    DMA_READ_ACK = state_q == S_ACK && cur_q == CH_RX;
    DMA_WRITE_DONE = DMA_WRITE_ACK && cur_rem == '0;
    DMA_READ_DONE = DMA_READ_ACK && cur_rem == '0;
    busy = state_q != S_IDLE;
    err_irq = err_q;
  end
endmodule

// File: tb/tb_wifi_ahb_dma_master.sv
// tb_wifi_ahb_dma_master: randomized AHB slave/PHY environment with a block-level reference model
module tb_wifi_ahb_dma_master;
  localparam logic [31:0] TXF = 32'h4000_0010;
  localparam logic [31:0] RXF = 32'h4000_0014;
  logic HCLK = 1'b0;
  logic reset = 1'b1;
  always #5 HCLK = ~HCLK;
  wifi_ahb_dma_master_if ahb();
  logic wreq = 1'b0, rreq = 1'b0, tx_start = 1'b0, rx_start = 1'b0;
  logic [31:0] cfg_tx_addr = '0, cfg_rx_addr = '0;
  logic [15:0] cfg_tx_len = '0, cfg_rx_len = '0;
  logic wack, rack, wdone, rdone, busy, err_irq;
  wifi_ahb_dma_master dut (
    .HCLK(HCLK), .reset(reset), .ahb(ahb),
    .DMA_WRITE_REQ(wreq), .DMA_READ_REQ(rreq),
    .DMA_WRITE_ACK(wack), .DMA_READ_ACK(rack), .DMA_WRITE_DONE(wdone), .DMA_READ_DONE(rdone),
    .tx_start(tx_start), .rx_start(rx_start),
    .cfg_tx_addr(cfg_tx_addr), .cfg_rx_addr(cfg_rx_addr), .cfg_tx_len(cfg_tx_len), .cfg_rx_len(cfg_rx_len),
    .busy(busy), .err_irq(err_irq)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;
  // memory content not yet written is a fixed function of its address
  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rx_sent[$], tx_got[$];
  int blk_ch[$], blk_n[$];
  int n_mwr = 0, err_wr = -1, wait_lo = 0, wait_hi = 0, wleft = 0;
  int n_wack = 0, n_rack = 0, n_wdone = 0, n_rdone = 0, ack_cyc = 0, start_cyc = 0, n_nonseq = 0;
  int tx_since = 0, rx_since = 0;
  logic dp_valid = 1'b0, dp_write = 1'b0, ph_on = 1'b0, stab_v = 1'b0, rnd_req = 1'b0;
  logic [31:0] dp_addr = '0, stab_a = '0;
  logic [1:0] stab_t = '0;
  always @(negedge HCLK) begin : slave
    logic [31:0] v;
    if (reset) begin
      dp_valid = 1'b0;
      ph_on = 1'b0;
      stab_v = 1'b0;
      ahb.HREADY = 1'b1;
      ahb.HRESP = 1'b0;
    end else begin
      if (stab_v) begin
        chk("haddr_stable", ahb.HADDR, stab_a);
        chk("htrans_stable", {30'd0, ahb.HTRANS}, {30'd0, stab_t});
      end
      if (wack) begin blk_ch.push_back(0); blk_n.push_back(tx_since); tx_since = 0; n_wack++; ack_cyc = cyc; end
      if (rack) begin blk_ch.push_back(1); blk_n.push_back(rx_since); rx_since = 0; n_rack++; ack_cyc = cyc; end
      if (wdone) begin n_wdone++; chk("wdone_with_ack", {31'd0, wack}, 32'd1); end
      if (rdone) begin n_rdone++; chk("rdone_with_ack", {31'd0, rack}, 32'd1); end
      if (ahb.HTRANS == 2'b10) n_nonseq++;
      ahb.HRESP = 1'b0;
      ahb.HRDATA = $urandom;
      if (!(dp_valid || ahb.HTRANS == 2'b10)) ahb.HREADY = 1'b1;
      else begin
        if (!ph_on) begin ph_on = 1'b1; wleft = $urandom_range(wait_hi, wait_lo); end
        ahb.HREADY = (wleft == 0);
        if (wleft > 0) wleft--; else ph_on = 1'b0;
      end
      stab_v = ahb.HTRANS == 2'b10 && !ahb.HREADY;
      stab_a = ahb.HADDR;
      stab_t = ahb.HTRANS;
      if (dp_valid && ahb.HREADY) begin
        dp_valid = 1'b0;
        if (dp_write) begin
          if (dp_addr == TXF) begin tx_got.push_back(ahb.HWDATA); tx_since++; end
          else begin
            if (n_mwr == err_wr) ahb.HRESP = 1'b1;
            else begin mem[dp_addr] = ahb.HWDATA; rx_since++; end
            n_mwr++;
          end
        end else if (dp_addr == RXF) begin
          v = $urandom;
          rx_sent.push_back(v);
          ahb.HRDATA = v;
        end else ahb.HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : seed_word(dp_addr);
      end else if (ahb.HTRANS == 2'b10 && ahb.HREADY) begin
        dp_valid = 1'b1;
        dp_write = ahb.HWRITE;
        dp_addr = ahb.HADDR;
      end
    end
  end
  task automatic clear_logs();
    mem.delete(); rx_sent.delete(); tx_got.delete(); blk_ch.delete(); blk_n.delete();
    n_mwr = 0; n_wack = 0; n_rack = 0; n_wdone = 0; n_rdone = 0; tx_since = 0; rx_since = 0;
  endtask
  task automatic do_reset();
    @(negedge HCLK);
    reset = 1'b1;
    wreq = 1'b0; rreq = 1'b0; err_wr = -1; wait_lo = 0; wait_hi = 0;
    @(negedge HCLK);
    reset = 1'b0;
    clear_logs();
  endtask
  task automatic start_tx(input logic [31:0] a, input int len);
    @(negedge HCLK);
    cfg_tx_addr = a; cfg_tx_len = 16'(len); tx_start = 1'b1; start_cyc = cyc;
    @(negedge HCLK);
    tx_start = 1'b0;
  endtask
  task automatic start_rx(input logic [31:0] a, input int len);
    @(negedge HCLK);
    cfg_rx_addr = a; cfg_rx_len = 16'(len); rx_start = 1'b1;
    @(negedge HCLK);
    rx_start = 1'b0;
  endtask
  task automatic start_both(input logic [31:0] a, input int lt, input logic [31:0] b, input int lr);
    @(negedge HCLK);
    cfg_tx_addr = a; cfg_tx_len = 16'(lt); cfg_rx_addr = b; cfg_rx_len = 16'(lr);
    tx_start = 1'b1; rx_start = 1'b1;
    @(negedge HCLK);
    tx_start = 1'b0; rx_start = 1'b0;
  endtask
  task automatic wait_done(input int etx, input int erx, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_wdone >= etx && n_rdone >= erx && !busy) break;
      if (rnd_req) begin wreq = $urandom_range(0, 3) != 0; rreq = $urandom_range(0, 3) != 0; end
      @(negedge HCLK);
    end
    chk("tx_done_cnt", n_wdone, etx);
    chk("rx_done_cnt", n_rdone, erx);
  endtask
  task automatic check_tx(input logic [31:0] a, input int len);
    chk("tx_words", tx_got.size(), len);
    for (int i = 0; i < len && i < tx_got.size(); i++) chk("tx_data", tx_got[i], seed_word(a + 32'(4 * i)));
  endtask
  task automatic check_rx(input logic [31:0] b, input int len);
    logic [31:0] ad;
    chk("rx_words", rx_sent.size(), len);
    chk("rx_mem_cnt", mem.num(), len);
    for (int i = 0; i < len && i < rx_sent.size(); i++) begin
      ad = b + 32'(4 * i);
      chk("rx_mem", mem.exists(ad) ? mem[ad] : ~rx_sent[i], rx_sent[i]);
    end
  endtask
  task automatic check_blocks(input int ch, input int len);
    int got[$];
    int rem, k, b;
    foreach (blk_ch[i]) if (blk_ch[i] == ch) got.push_back(blk_n[i]);
    rem = len; k = 0;
    while (rem > 0) begin
      b = rem < 4 ? rem : 4;
      chk(ch == 0 ? "tx_blk_size" : "rx_blk_size", k < got.size() ? got[k] : -1, b);
      rem -= b; k++;
    end
    chk(ch == 0 ? "tx_blk_cnt" : "rx_blk_cnt", got.size(), k);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, b;
    int lt, lr, base;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", {30'd0, ahb.HTRANS}, 32'd0);
    chk("rst_haddr", ahb.HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, ahb.HWRITE}, 32'd0);
    chk("rst_hwdata", ahb.HWDATA, 32'd0);
    chk("rst_flags", {26'd0, busy, err_irq, wack, rack, wdone, rdone}, 32'd0);
    chk("hsize", {29'd0, ahb.HSIZE}, 32'd2);
    chk("hburst", {29'd0, ahb.HBURST}, 32'd0);
    reset = 1'b0;
    clear_logs();
    // T1: single TX transfer, zero-wait latency
    wreq = 1'b1;
    start_tx(32'h2000_0000, 3);
    wait_done(1, 0, 200);
    chk("t1_latency", ack_cyc - start_cyc, 15);
    chk("t1_acks", n_wack, 1);
    check_tx(32'h2000_0000, 3);
    chk("t1_mem_writes", n_mwr, 0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    // T2: RX len 10 splits 4,4,2; second start while armed is ignored
    do_reset();
    rreq = 1'b1;
    start_rx(32'h3000_0100, 10);
    start_rx(32'h3800_0000, 3);
    wait_done(0, 1, 400);
    chk("t2_acks", n_rack, 3);
    check_rx(32'h3000_0100, 10);
    check_blocks(1, 10);
    // T3: both requesting from reset alternate TX first
    do_reset();
    wreq = 1'b1; rreq = 1'b1;
    start_both(32'h2000_0400, 8, 32'h3000_0400, 8);
    wait_done(1, 1, 400);
    chk("t3_blocks", blk_ch.size(), 4);
    for (int i = 0; i < 4 && i < blk_ch.size(); i++) chk("t3_order", blk_ch[i], i % 2);
    check_tx(32'h2000_0400, 8);
    check_rx(32'h3000_0400, 8);
    // T4: three wait states on every phase
    do_reset();
    wait_lo = 3; wait_hi = 3;
    wreq = 1'b1; rreq = 1'b1;
    start_both(32'h2000_0800, 5, 32'h3000_0800, 6);
    wait_done(1, 1, 1000);
    check_tx(32'h2000_0800, 5);
    check_rx(32'h3000_0800, 6);
    check_blocks(0, 5);
    check_blocks(1, 6);
    // randomized lengths, addresses, waits and REQ levels; first run wraps the address space
    for (int it = 0; it < 6; it++) begin
      do_reset();
      wait_lo = 0; wait_hi = 2;
      a = (it == 0) ? 32'hFFFF_FFF9 : (32'h1000_0000 | ($urandom & 32'h00FF_FFFF));
      b = 32'h3000_0000 | ($urandom & 32'h00FF_FFFF);
      lt = $urandom_range(1, 12);
      lr = $urandom_range(1, 12);
      rnd_req = 1'b1;
      start_both(a, lt, b, lr);
      wait_done(1, 1, 3000);
      rnd_req = 1'b0;
      check_tx(a & ~32'd3, lt);
      check_rx(b & ~32'd3, lr);
      check_blocks(0, lt);
      check_blocks(1, lr);
    end
    // T5: error on second RX write aborts the channel
    do_reset();
    err_wr = 1;
    rreq = 1'b1;
    start_rx(32'h3000_1000, 6);
    for (int i = 0; i < 200 && !err_irq; i++) @(negedge HCLK);
    chk("t5_err_irq", {31'd0, err_irq}, 32'd1);
    repeat (30) @(negedge HCLK);
    chk("t5_no_ack", n_rack, 0);
    chk("t5_no_done", n_rdone, 0);
    chk("t5_mem_attempts", n_mwr, 2);
    chk("t5_mem_words", mem.num(), 1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    err_wr = -1;
    start_rx(32'h3000_2000, 2);
    chk("t5_err_clear", {31'd0, err_irq}, 32'd0);
    wait_done(0, 1, 200);
    // T6: async reset during a write address phase, then a zero-length start
    do_reset();
    wreq = 1'b1;
    start_tx(32'h2000_3000, 8);
    for (int i = 0; i < 100 && !(ahb.HTRANS == 2'b10 && ahb.HWRITE); i++) @(negedge HCLK);
    chk("t6_in_wr_a", {31'd0, ahb.HWRITE}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_htrans", {30'd0, ahb.HTRANS}, 32'd0);
    chk("t6_haddr", ahb.HADDR, 32'd0);
    chk("t6_flags", {29'd0, ahb.HWRITE, busy, wack}, 32'd0);
    @(negedge HCLK);
    reset = 1'b0;
    base = n_nonseq;
    repeat (20) @(negedge HCLK);
    chk("t6_disarmed", n_nonseq - base, 0);
    chk("t6_lost_word", tx_got.size(), 0);
    start_tx(32'h2000_4000, 0);
    repeat (20) @(negedge HCLK);
    chk("t6_len0_idle", n_nonseq - base, 0);
    chk("t6_len0_done", n_wdone, 0);
    chk("t6_len0_busy", {31'd0, busy}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
